fir_decim_buffer: RTL and testbench

- Downstream stage of the 16-bit FIR low-pass filter. Consumes the filter output at the filter sample rate.
- Discards the filter's start-up transient, then decimates by an integer ratio.
- Buffers kept samples in a small show-ahead FIFO and presents them on a valid/ready stream to the next consumer (e.g. a capture or UART logger).
- Flags and drops samples when the consumer stalls long enough to fill the FIFO.

---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_decim_buffer_sync_fifo_sa.sv | 65 ++++++
 rtl/fir_decim_buffer.sv | 111 +++++++++++
 tb/tb_fir_decim_buffer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types for the FIR output path.
// Sample type, default width and decimator state encoding.
package fir_pkg;

  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] sample_t;

  typedef enum logic {
    SKIP_ST,
    RUN
  } state_e;

endpackage

// File: rtl/fir_decim_buffer_sync_fifo_sa.sv
// Show-ahead synchronous FIFO; head entry is always on rdata.
// Full and empty are told apart by the occupancy counter.
module sync_fifo_sa #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [LW-1:0]     level_q, level_d;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a write when the head leaves this cycle.
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_d    = wr_q + AW'(push_ok);
    rd_d    = rd_q + AW'(pop_ok);
    level_d = level_q + LW'(push_ok) - LW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wr_q] <= wdata;
    end
  end

  assign rdata = empty ? '0 : mem_q[rd_q];
  assign level = level_q;

endmodule

// File: rtl/fir_decim_buffer.sv
// FIR output stage: drop start-up transient, decimate, buffer.
// Kept samples stream out valid/ready; drops on full are flagged.
module fir_decim_buffer
  import fir_pkg::*;
#(
  parameter int DATA_W = fir_pkg::DATA_W,
  parameter int DECIM  = 4,
  parameter int SKIP   = 32,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic [DATA_W-1:0]      filter_in,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  localparam int SW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam state_e RST_ST = (SKIP > 0) ? SKIP_ST : RUN;

  state_e        state_q, state_d;
  logic [SW-1:0] skip_q, skip_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          overflow_q, overflow_d;
  logic          keep;
  logic          pop;
  logic          drop;
  logic          full;
  logic          empty;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    phase_d = phase_q;
    keep    = 1'b0;
    unique case (state_q)
      SKIP_ST: begin
        if (clk_en) begin
          skip_d = skip_q + SW'(1);
          if (int'(skip_q) == SKIP - 1) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (clk_en) begin
          keep = (phase_q == '0);
          if (int'(phase_q) == DECIM - 1) begin
            phase_d = '0;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end
      default: state_d = RST_ST;
    endcase
  end

  assign pop  = m_valid && m_ready;
  assign drop = keep && full && !pop;

  // A drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_ST;
      skip_q     <= '0;
      phase_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo_sa #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (keep),
    .pop   (pop),
    .wdata (filter_in),
    .rdata (m_data),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign m_valid  = !empty;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Directed bench for fir_decim_buffer.
// Three instances cover the skip, decimation and overflow cases.
module tb_fir_decim_buffer;

  logic clk;
  logic rst_n;

  logic        a_en, a_ready, a_clr;
  logic [15:0] a_in, a_data;
  logic        a_valid, a_ovf;
  logic [3:0]  a_level;

  logic        b_en, b_ready, b_clr;
  logic [15:0] b_in, b_data;
  logic        b_valid, b_ovf;
  logic [3:0]  b_level;

  logic        c_en, c_ready, c_clr;
  logic [15:0] c_in, c_data;
  logic        c_valid, c_ovf;
  logic [3:0]  c_level;

  int checks;
  int failures;

  fir_decim_buffer #(
    .DATA_W (16), .DECIM (4), .SKIP (4), .DEPTH (8)
  ) u_a (
    .clk (clk), .rst_n (rst_n), .clk_en (a_en),
    .filter_in (a_in), .m_data (a_data),
    .m_valid (a_valid), .m_ready (a_ready),
    .level (a_level), .overflow (a_ovf),
    .clr_ovf (a_clr)
  );

  fir_decim_buffer #(
    .DATA_W (16), .DECIM (2), .SKIP (0), .DEPTH (8)
  ) u_b (
    .clk (clk), .rst_n (rst_n), .clk_en (b_en),
    .filter_in (b_in), .m_data (b_data),
    .m_valid (b_valid), .m_ready (b_ready),
    .level (b_level), .overflow (b_ovf),
    .clr_ovf (b_clr)
  );

  fir_decim_buffer #(
    .DATA_W (16), .DECIM (1), .SKIP (0), .DEPTH (8)
  ) u_c (
    .clk (clk), .rst_n (rst_n), .clk_en (c_en),
    .filter_in (c_in), .m_data (c_data),
    .m_valid (c_valid), .m_ready (c_ready),
    .level (c_level), .overflow (c_ovf),
    .clr_ovf (c_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_v;
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    a_en = 0; a_ready = 0; a_clr = 0; a_in = '0;
    b_en = 0; b_ready = 0; b_clr = 0; b_in = '0;
    c_en = 0; c_ready = 0; c_clr = 0; c_in = '0;

    #12;
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_a_level", a_level, 0);
    chk("rst_a_ovf", a_ovf, 0);
    chk("rst_c_valid", c_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // skip 4, decimate 4, ramp 0..20
    a_ready = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      a_en = 1'b1;
      a_in = 16'(i);
      step();
      exp_v = (i >= 4) && (i % 4 == 0);
      chk($sformatf("t1_valid_%0d", i), a_valid, exp_v);
      if (exp_v) begin
        chk($sformatf("t1_data_%0d", i), a_data, i);
      end
    end
    a_en = 1'b0;
    step();
    chk("t1_ovf", a_ovf, 0);
    chk("t1_level", a_level, 0);

    // strobes on alternate cycles, idle value is junk
    b_ready = 1'b1;
    for (int j = 0; j <= 8; j++) begin
      b_en = (j % 2 == 0);
      b_in = b_en ? 16'(j / 2) : 16'h7777;
      step();
      exp_v = b_en && ((j / 2) % 2 == 0);
      chk($sformatf("t2_valid_%0d", j), b_valid, exp_v);
      if (exp_v) begin
        chk($sformatf("t2_data_%0d", j), b_data, j / 2);
      end
    end
    b_en = 1'b0;

    // fill past depth with consumer stalled
    c_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      c_en = 1'b1;
      c_in = 16'h0100 + 16'(i);
      step();
    end
    c_en = 1'b0;
    chk("t3_level", c_level, 8);
    chk("t3_ovf", c_ovf, 1);
    chk("t3_head", c_data, 16'h0100);
    c_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_drain_%0d", i), c_data,
          16'h0100 + 16'(i));
      step();
    end
    chk("t3_empty_valid", c_valid, 0);
    chk("t3_empty_level", c_level, 0);
    c_ready = 1'b0;

    c_clr = 1'b1;
    step();
    c_clr = 1'b0;
    chk("t4_clr", c_ovf, 0);
    for (int i = 0; i < 8; i++) begin
      c_en = 1'b1;
      c_in = 16'h0300 + 16'(i);
      step();
    end
    chk("t4_full", c_level, 8);
    // full, pop and push together
    c_ready = 1'b1;
    c_in    = 16'h0308;
    step();
    chk("t4_level", c_level, 8);
    chk("t4_ovf", c_ovf, 0);
    chk("t4_head", c_data, 16'h0301);

    // drop and clear in one cycle
    c_ready = 1'b0;
    c_in    = 16'h0309;
    c_clr   = 1'b1;
    step();
    chk("t5_set_wins", c_ovf, 1);
    chk("t5_level", c_level, 8);
    chk("t5_head", c_data, 16'h0301);
    c_en = 1'b0;
    step();
    chk("t5_clr_alone", c_ovf, 0);
    c_clr = 1'b0;

    c_en = 1'b1;
    c_in = 16'h030A;
    step();
    c_en = 1'b0;
    chk("t6_ovf_pre", c_ovf, 1);
    c_ready = 1'b1;
    step();
    step();
    step();
    c_ready = 1'b0;
    chk("t6_level_pre", c_level, 5);
    chk("t6_head_pre", c_data, 16'h0304);

    // asynchronous reset mid-cycle
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", c_valid, 0);
    chk("t6_rst_level", c_level, 0);
    chk("t6_rst_ovf", c_ovf, 0);
    chk("t6_rst_data", c_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    a_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_en = 1'b1;
      a_in = 16'h1111;
      step();
      chk($sformatf("t6_skip_%0d", i), a_valid, 0);
    end
    a_in = 16'h8000;
    step();
    chk("t6_8000_valid", a_valid, 1);
    chk("t6_8000_data", a_data, 16'h8000);
    for (int i = 0; i < 3; i++) begin
      a_in = 16'h2222;
      step();
      chk($sformatf("t6_gap_%0d", i), a_valid, 0);
    end
    a_in = 16'hFFFF;
    step();
    chk("t6_ffff_valid", a_valid, 1);
    chk("t6_ffff_data", a_data, 16'hFFFF);
    a_en = 1'b0;
    step();
    chk("t6_final_ovf", a_ovf, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
